// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared FSM states, PIO address and default sizes for the LED sequencer
package led_seq_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, COUNT} state_t;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF = 24;
  localparam int STEPS_DEF = 4;
endpackage

// File: rtl/led_seq_pattern_ram.sv
// led_seq_pattern_ram: STEPS x DATA_W pattern table; sync write/reset (clk, reset, we, waddr, wdata), async read (raddr -> rdata)
module led_seq_pattern_ram
  import led_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int STEPS = STEPS_DEF,
  localparam int IDX_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [STEPS];
  always_ff @(posedge clk)
    if (reset) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/led_pio_sequencer.sv
// led_pio_sequencer: Avalon-MM master stepping a pattern table onto the LED PIO (clk, reset, enable, period, last_step, cfg_* in; pio_* bus, busy, step_idx out)
module led_pio_sequencer
  import led_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int STEPS = STEPS_DEF,
  localparam int IDX_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  period,
  input  logic [IDX_W-1:0]  last_step,
  input  logic              cfg_load,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_data,
  output logic [1:0]        pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [DATA_W-1:0] pio_writedata,
  output logic              busy,
  output logic [IDX_W-1:0]  step_idx
);
  state_t state;
  logic [DIV_W-1:0] cnt, per_q, p_eff;
  logic [DATA_W-1:0] rdata;
  logic expire, start;
  // cnt is 0 in the WRITE cycle, so expiry one short of the spacing lands the next WRITE exactly on it
  assign p_eff = per_q < DIV_W'(2) ? DIV_W'(2) : per_q;
  assign expire = state == COUNT && cnt >= p_eff - DIV_W'(1);
  assign start = enable && (state == IDLE || expire);
  assign pio_address = PIO_DATA_ADDR;
  led_seq_pattern_ram #(.DATA_W(DATA_W), .STEPS(STEPS)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_load),
    .waddr (cfg_idx),
    .wdata (cfg_data),
    .raddr (step_idx),
    .rdata (rdata)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      step_idx <= '0;
      cnt <= '0;
      per_q <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n <= 1'b1;
      pio_writedata <= '0;
      busy <= 1'b0;
    end else begin
      state <= start ? WRITE : state == WRITE ? COUNT : expire ? IDLE : state;
      busy <= start || state == WRITE || (state == COUNT && !expire);
      pio_chipselect <= start;
      pio_write_n <= !start;
      cnt <= start ? '0 : state == IDLE ? cnt : cnt + DIV_W'(1);
      if (start) begin
        pio_writedata <= rdata;
        per_q <= period;
        step_idx <= step_idx == last_step ? '0 : step_idx + IDX_W'(1);
      end
    end
endmodule

// File: tb/tb_led_pio_sequencer.sv
// tb_led_pio_sequencer: directed self-checking bench for led_pio_sequencer
module tb_led_pio_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [23:0] period = '0;
  logic [1:0] last_step = '0;
  logic cfg_load = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [7:0] cfg_data = '0;
  logic [1:0] pio_address;
  logic pio_chipselect, pio_write_n, busy;
  logic [7:0] pio_writedata;
  logic [1:0] step_idx;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_pio_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .period         (period),
    .last_step      (last_step),
    .cfg_load       (cfg_load),
    .cfg_idx        (cfg_idx),
    .cfg_data       (cfg_data),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .busy           (busy),
    .step_idx       (step_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] d0, d1, d2, d3);
    logic [7:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      cfg_load = 1'b1;
      cfg_idx = 2'(i);
      cfg_data = d[i];
      tick();
    end
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pio_chipselect, pio_write_n, pio_writedata, busy, step_idx, pio_address} !== {1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 2'd0}) begin
        failures++;
        $display("FAIL reset_defaults cyc=%0d cs=%b wn=%b wd=%h busy=%b step=%0d addr=%0d expected cs=0 wn=1 wd=00 busy=0 step=0 addr=0",
                 i, pio_chipselect, pio_write_n, pio_writedata, busy, step_idx, pio_address);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({pio_chipselect, pio_write_n, pio_writedata, busy} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL reset_first_write cs=%b wn=%b wd=%h busy=%b expected cs=1 wn=0 wd=00 busy=1",
               pio_chipselect, pio_write_n, pio_writedata, busy);
    end
  endtask

  task automatic test_chase();
    logic [7:0] e [4];
    e = '{8'h01, 8'h02, 8'h04, 8'h08};
    do_reset();
    load(8'h01, 8'h02, 8'h04, 8'h08);
    last_step = 2'd3;
    period = 24'd5;
    enable = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      checks++;
      if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {k % 5 == 0, k % 5 != 0, 2'd0, e[(k / 5) % 4]}) begin
        failures++;
        $display("FAIL chase k=%0d cs=%b wn=%b addr=%0d wd=%h expected cs=%b wd=%h",
                 k, pio_chipselect, pio_write_n, pio_address, pio_writedata, k % 5 == 0, e[(k / 5) % 4]);
      end
    end
  endtask

  task automatic test_short_wrap();
    logic [7:0] e [2];
    e = '{8'hAA, 8'h55};
    do_reset();
    load(8'hAA, 8'h55, 8'h11, 8'h22);
    last_step = 2'd1;
    period = 24'd0;
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({pio_chipselect, pio_writedata, step_idx} !== {k % 2 == 0, e[(k / 2) % 2], 2'(((k / 2) + 1) % 2)}) begin
        failures++;
        $display("FAIL short_wrap k=%0d cs=%b wd=%h step=%0d expected cs=%b wd=%h step=%0d",
                 k, pio_chipselect, pio_writedata, step_idx, k % 2 == 0, e[(k / 2) % 2], ((k / 2) + 1) % 2);
      end
    end
  endtask

  task automatic test_stop_restart();
    do_reset();
    load(8'h01, 8'h02, 8'h04, 8'h08);
    last_step = 2'd3;
    period = 24'd8;
    enable = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      tick();
      checks++;
      if (k == 8 && {pio_chipselect, pio_writedata} !== {1'b1, 8'h02}) begin
        failures++;
        $display("FAIL stop_second_write cs=%b wd=%h expected cs=1 wd=02", pio_chipselect, pio_writedata);
      end else if (k > 8 && k < 16 && {pio_chipselect, busy, step_idx} !== {1'b0, 1'b1, 2'd2}) begin
        failures++;
        $display("FAIL stop_draining k=%0d cs=%b busy=%b step=%0d expected cs=0 busy=1 step=2", k, pio_chipselect, busy, step_idx);
      end else if (k >= 16 && k <= 18 && {pio_chipselect, busy, step_idx} !== {1'b0, 1'b0, 2'd2}) begin
        failures++;
        $display("FAIL stop_idle k=%0d cs=%b busy=%b step=%0d expected cs=0 busy=0 step=2", k, pio_chipselect, busy, step_idx);
      end else if (k == 19 && {pio_chipselect, pio_writedata, busy} !== {1'b1, 8'h04, 1'b1}) begin
        failures++;
        $display("FAIL restart_write cs=%b wd=%h busy=%b expected cs=1 wd=04 busy=1", pio_chipselect, pio_writedata, busy);
      end
      if (k == 8) enable = 1'b0;
      if (k == 18) enable = 1'b1;
    end
  endtask

  task automatic test_load_collision();
    logic [7:0] e [6];
    e = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'hF0};
    do_reset();
    load(8'h01, 8'h02, 8'h04, 8'h08);
    last_step = 2'd3;
    period = 24'd5;
    enable = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      tick();
      cfg_load = 1'b0;
      if (k % 5 == 0) begin
        checks++;
        if ({pio_chipselect, pio_writedata} !== {1'b1, e[k / 5]}) begin
          failures++;
          $display("FAIL load_collision k=%0d cs=%b wd=%h expected cs=1 wd=%h", k, pio_chipselect, pio_writedata, e[k / 5]);
        end
      end
      if (k == 4) begin
        cfg_load = 1'b1;
        cfg_idx = 2'd1;
        cfg_data = 8'hF0;
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    load(8'h01, 8'h02, 8'h04, 8'h08);
    last_step = 2'd3;
    period = 24'd5;
    enable = 1'b1;
    tick();
    checks++;
    if ({pio_chipselect, pio_writedata} !== {1'b1, 8'h01}) begin
      failures++;
      $display("FAIL midreset_pre cs=%b wd=%h expected cs=1 wd=01", pio_chipselect, pio_writedata);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({pio_chipselect, pio_write_n, pio_writedata, busy, step_idx} !== {1'b0, 1'b1, 8'h00, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL midreset_outputs cs=%b wn=%b wd=%h busy=%b step=%0d expected cs=0 wn=1 wd=00 busy=0 step=0",
               pio_chipselect, pio_write_n, pio_writedata, busy, step_idx);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({pio_chipselect, pio_writedata, step_idx} !== {1'b1, 8'h00, 2'd1}) begin
      failures++;
      $display("FAIL midreset_restart cs=%b wd=%h step=%0d expected cs=1 wd=00 step=1", pio_chipselect, pio_writedata, step_idx);
    end
  endtask

  initial begin
    test_reset();
    test_chase();
    test_short_wrap();
    test_stop_restart();
    test_load_collision();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
